// File: rtl/morse_tx_arbiter.sv
// morse_tx_arbiter: round-robin message arbiter in front of the morse_tx
// write port. Grants whole messages, optionally appends a separator byte,
// and drops an owner that stays idle for too long.
module morse_tx_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter bit          SEP_EN   = 1'b1,
  parameter logic [7:0]  SEP_CHAR = 8'h20,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               write_en,
  output logic [7:0]         ascii_in,
  input  logic               full,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter keeps at least one bit so a disabled timeout still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    SEP
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pick;
  logic             pick_found;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  assign busy = (state != IDLE);

  // Encode the one-hot grant into the owner index.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) owner = IDX_W'(i);
    end
  end

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int unsigned idx;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_grant) + k) % N_REQ;
      if (!pick_found && req_valid[IDX_W'(idx)]) begin
        pick_found = 1'b1;
        pick       = IDX_W'(idx);
      end
    end
  end

  // Next-state logic and combinational handshake outputs.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    idle_cnt_nxt   = idle_cnt;
    req_ready      = '0;
    write_en       = 1'b0;
    ascii_in       = '0;
    timeout_err    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          idle_cnt_nxt    = '0;
          state_nxt       = XFER;
        end
      end
      XFER: begin
        req_ready[owner] = ~full;
        if (!full) begin
          if (req_valid[owner]) begin
            write_en     = 1'b1;
            ascii_in     = req_data[{owner, 3'b000} +: 8];
            idle_cnt_nxt = '0;
            if (req_last[owner]) begin
              last_grant_nxt = owner;
              grant_nxt      = '0;
              if (SEP_EN) state_nxt = SEP;
              else        state_nxt = IDLE;
            end
          end else begin
            if (idle_cnt != '1) idle_cnt_nxt = idle_cnt + 1'b1;
            if ((TIMEOUT != 0) && (idle_cnt == CNT_LAST)) begin
              timeout_err    = 1'b1;
              last_grant_nxt = owner;
              grant_nxt      = '0;
              if (SEP_EN) state_nxt = SEP;
              else        state_nxt = IDLE;
            end
          end
        end
      end
      SEP: begin
        write_en = ~full;
        ascii_in = SEP_CHAR;
        if (!full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A byte presented while reset is asserted is dropped, not written.
    if (rst) begin
      req_ready   = '0;
      write_en    = 1'b0;
      ascii_in    = '0;
      timeout_err = 1'b0;
    end
  end

  // State, grant, round-robin pointer and idle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      idle_cnt   <= idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Bench for morse_tx_arbiter: directed vector table, hand sequences for
// stall/timeout/no-separator cases, and a randomized message run checked
// against a round-robin message-order model.
module tb_morse_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        full;

  logic [3:0] ready, grant;
  logic       we, busy, to;
  logic [7:0] asc;
  logic [3:0] ready_n, grant_n;
  logic       we_n, busy_n, to_n;
  logic [7:0] asc_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  morse_tx_arbiter #(.N_REQ(4), .SEP_EN(1'b1), .SEP_CHAR(8'h20), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready), .write_en(we), .ascii_in(asc),
    .full(full), .grant(grant), .busy(busy), .timeout_err(to)
  );

  morse_tx_arbiter #(.N_REQ(4), .SEP_EN(1'b0), .SEP_CHAR(8'h20), .TIMEOUT(0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_n), .write_en(we_n), .ascii_in(asc_n),
    .full(full), .grant(grant_n), .busy(busy_n), .timeout_err(to_n)
  );

  typedef struct {
    string       name;
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        f;
    logic [3:0]  er;
    logic        ew;
    logic [7:0]  ea;
    logic [3:0]  eg;
    logic        eb;
    logic        et;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic f);
    @(negedge clk);
    rst = r; req_valid = v; req_data = d; req_last = l; full = f;
    #1;
  endtask

  task automatic step(input string name, input logic r, input logic [3:0] v,
                      input logic [31:0] d, input logic [3:0] l, input logic f,
                      input logic [3:0] er, input logic ew, input logic [7:0] ea,
                      input logic [3:0] eg, input logic eb, input logic et);
    drive(r, v, d, l, f);
    chk({name, ".ready"}, 32'(ready), 32'(er));
    chk({name, ".write_en"}, 32'(we), 32'(ew));
    if (ew) chk({name, ".ascii"}, 32'(asc), 32'(ea));
    chk({name, ".grant"}, 32'(grant), 32'(eg));
    chk({name, ".busy"}, 32'(busy), 32'(eb));
    chk({name, ".timeout"}, 32'(to), 32'(et));
  endtask

  task automatic step_ns(input string name, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic ew, input logic [7:0] ea,
                         input logic [3:0] eg, input logic eb);
    drive(1'b0, v, d, l, 1'b0);
    chk({name, ".write_en"}, 32'(we_n), 32'(ew));
    if (ew) chk({name, ".ascii"}, 32'(asc_n), 32'(ea));
    chk({name, ".grant"}, 32'(grant_n), 32'(eg));
    chk({name, ".busy"}, 32'(busy_n), 32'(eb));
  endtask

  task automatic add(input string name, input logic r, input logic [3:0] v,
                     input logic [31:0] d, input logic [3:0] l, input logic f,
                     input logic [3:0] er, input logic ew, input logic [7:0] ea,
                     input logic [3:0] eg, input logic eb, input logic et);
    vec_t t;
    t.name = name; t.r = r; t.v = v; t.d = d; t.l = l; t.f = f;
    t.er = er; t.ew = ew; t.ea = ea; t.eg = eg; t.eb = eb; t.et = et;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0, 32'b0, 4'b0, 1'b0);
    drive(1'b1, 4'b0, 32'b0, 4'b0, 1'b0);
  endtask

  // Random-run storage: up to 3 messages of 1..4 bytes per requester.
  logic [7:0]  rd [4][16];
  logic        rl [4][16];
  int unsigned len[4], ptr[4], gap[4], mp[4];
  logic [7:0]  expq[$];

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; full = 1'b0;

    // Reset state, SOS message with separator
    add("reset",  0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t1_arb", 0, 4'b0001, 32'h53, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t1_s1",  0, 4'b0001, 32'h53, 4'b0000, 0, 4'b0001, 1, 8'h53, 4'b0001, 1, 0);
    add("t1_o",   0, 4'b0001, 32'h4f, 4'b0000, 0, 4'b0001, 1, 8'h4f, 4'b0001, 1, 0);
    add("t1_s2",  0, 4'b0001, 32'h53, 4'b0001, 0, 4'b0001, 1, 8'h53, 4'b0001, 1, 0);
    add("t1_sep", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    add("t1_end", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    // Round-robin between req0 and req2, single-byte messages
    add("t2_rst", 1, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t2_arb", 0, 4'b0101, 32'h00430041, 4'b0101, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t2_r0",  0, 4'b0101, 32'h00430041, 4'b0101, 0, 4'b0001, 1, 8'h41, 4'b0001, 1, 0);
    add("t2_sep", 0, 4'b0100, 32'h00430000, 4'b0100, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    add("t2_ar2", 0, 4'b0100, 32'h00430000, 4'b0100, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t2_r2",  0, 4'b0100, 32'h00430000, 4'b0100, 0, 4'b0100, 1, 8'h43, 4'b0100, 1, 0);
    add("t2_sp2", 0, 4'b0101, 32'h00430041, 4'b0101, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    add("t2_ar3", 0, 4'b0101, 32'h00430041, 4'b0101, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t2_wrap",0, 4'b0101, 32'h00430041, 4'b0101, 0, 4'b0001, 1, 8'h41, 4'b0001, 1, 0);
    add("t2_sp3", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    add("t2_end", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    // Reset while a message is in flight
    add("t6_arb", 0, 4'b0010, 32'h5800, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t6_rst", 1, 4'b0010, 32'h5800, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0010, 1, 0);
    add("t6_post",0, 4'b0010, 32'h5800, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add("t6_own", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0010, 0, 8'h00, 4'b0010, 1, 0);
    add("t6_rst2",1, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0010, 1, 0);
    add("t6_end", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f,
           tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].eg, tbl[i].eb, tbl[i].et);
    end

    // Full stall mid-message, then idle counter holding across full
    step("t3_arb", 0, 4'b0001, 32'h41, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    step("t3_a",   0, 4'b0001, 32'h41, 4'b0000, 0, 4'b0001, 1, 8'h41, 4'b0001, 1, 0);
    for (int i = 0; i < 5; i++)
      step("t3_stall", 0, 4'b0001, 32'h42, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0001, 1, 0);
    step("t3_b",   0, 4'b0001, 32'h42, 4'b0000, 0, 4'b0001, 1, 8'h42, 4'b0001, 1, 0);
    step("t3_gap", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0001, 0, 8'h00, 4'b0001, 1, 0);
    for (int i = 0; i < 5; i++)
      step("t3_gapfull", 0, 4'b0000, 32'h00, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0001, 1, 0);
    step("t3_gap2", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0001, 0, 8'h00, 4'b0001, 1, 0);
    step("t3_gap3", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0001, 0, 8'h00, 4'b0001, 1, 0);
    step("t3_tmo",  0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0001, 0, 8'h00, 4'b0001, 1, 1);
    step("t3_sep",  0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    step("t3_end",  0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // Timeout 4 cycles after last accept, then the waiting requester
    step("t4_arb", 0, 4'b0110, 32'h00595800, 4'b0100, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    step("t4_x",   0, 4'b0110, 32'h00595800, 4'b0100, 0, 4'b0010, 1, 8'h58, 4'b0010, 1, 0);
    for (int i = 0; i < 3; i++)
      step("t4_wait", 0, 4'b0100, 32'h00590000, 4'b0100, 0, 4'b0010, 0, 8'h00, 4'b0010, 1, 0);
    step("t4_tmo",  0, 4'b0100, 32'h00590000, 4'b0100, 0, 4'b0010, 0, 8'h00, 4'b0010, 1, 1);
    step("t4_sep",  0, 4'b0100, 32'h00590000, 4'b0100, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    step("t4_arb2", 0, 4'b0100, 32'h00590000, 4'b0100, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    step("t4_lastfull", 0, 4'b0100, 32'h00590000, 4'b0100, 1, 4'b0000, 0, 8'h00, 4'b0100, 1, 0);
    step("t4_y",    0, 4'b0100, 32'h00590000, 4'b0100, 0, 4'b0100, 1, 8'h59, 4'b0100, 1, 0);
    step("t4_sep2", 0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 1, 8'h20, 4'b0000, 1, 0);
    step("t4_end",  0, 4'b0000, 32'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // Separator disabled: back-to-back messages from req1 and req3
    do_reset();
    step_ns("t5_arb", 4'b1010, 32'h33003100, 4'b0000, 0, 8'h00, 4'b0000, 0);
    step_ns("t5_a1",  4'b1010, 32'h33003100, 4'b0000, 1, 8'h31, 4'b0010, 1);
    step_ns("t5_a2",  4'b1010, 32'h33003200, 4'b0010, 1, 8'h32, 4'b0010, 1);
    step_ns("t5_gap", 4'b1000, 32'h33000000, 4'b0000, 0, 8'h00, 4'b0000, 0);
    step_ns("t5_b1",  4'b1000, 32'h33000000, 4'b0000, 1, 8'h33, 4'b1000, 1);
    step_ns("t5_b2",  4'b1000, 32'h34000000, 4'b1000, 1, 8'h34, 4'b1000, 1);
    step_ns("t5_end", 4'b0000, 32'h00, 4'b0000, 0, 8'h00, 4'b0000, 0);

    // Randomized messages: expected write stream from round-robin message order
    for (int i = 0; i < 4; i++) begin
      len[i] = 0; ptr[i] = 0; gap[i] = 0; mp[i] = 0;
      for (int m = 0; m < 3; m++) begin
        int unsigned ml;
        ml = $urandom_range(1, 4);
        for (int unsigned b = 0; b < ml; b++) begin
          rd[i][len[i]] = 8'($urandom);
          rl[i][len[i]] = (b == ml - 1);
          len[i]++;
        end
      end
    end
    begin
      int last_owner, sel;
      bit done;
      last_owner = 3;
      forever begin
        sel = -1;
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (last_owner + k) % 4;
          if (sel < 0 && mp[j] < len[j]) sel = j;
        end
        if (sel < 0) break;
        done = 1'b0;
        while (!done) begin
          expq.push_back(rd[sel][mp[sel]]);
          done = rl[sel][mp[sel]];
          mp[sel]++;
        end
        expq.push_back(8'h20);
        last_owner = sel;
      end
    end

    do_reset();
    begin
      int unsigned obs, cycles;
      obs = 0; cycles = 0;
      while (obs < expq.size() && cycles < 3000) begin
        logic [3:0]  v, l;
        logic [31:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < 4; i++) begin
          if (ptr[i] < len[i]) begin
            bit at_start;
            at_start = (ptr[i] == 0) || rl[i][ptr[i]-1];
            if (!at_start && gap[i] < 2 && $urandom_range(0, 3) == 0) begin
              gap[i]++;
            end else begin
              v[i] = 1'b1;
            end
            d[8*i +: 8] = rd[i][ptr[i]];
            l[i]        = rl[i][ptr[i]];
          end
        end
        drive(1'b0, v, d, l, ($urandom_range(0, 3) == 0));
        cycles++;
        chk("rand.write_while_full", 32'(we & full), 32'd0);
        chk("rand.ready_outside_grant", 32'(ready & ~grant), 32'd0);
        chk("rand.timeout", 32'(to), 32'd0);
        if (we) begin
          chk("rand.byte", 32'(asc), 32'(expq[obs]));
          obs++;
        end
        for (int i = 0; i < 4; i++) begin
          if (req_valid[i] && ready[i]) begin
            ptr[i]++;
            gap[i] = 0;
          end
        end
      end
      chk("rand.complete", obs, expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
